// File: rtl/ctrl_pipe_unit_if.sv
// Control-pipe bundle between the IF/ID register, this decoder and the datapath stage registers.
// The slave side is the decoder; the master side drives the ID fields and consumes per-stage control.
interface ctrl_pipe_unit_if #(
  parameter int ALUOP_W = 4,
  parameter int RA_W    = 5
);
  logic               InValid;
  logic [5:0]         Instruction;
  logic [5:0]         Function;
  logic [RA_W-1:0]    Rs;
  logic [RA_W-1:0]    Rt;
  logic [RA_W-1:0]    Rd;
  logic               Flush;
  logic               Stall;
  logic               IllegalOp;
  logic               ExValid, ExRegDst, ExBranch, ExMemRead, ExMemtoReg, ExMemWrite;
  logic               ExALUSrc, ExRegWrite, ExJump, ExJumpReg, ExLink;
  logic [ALUOP_W-1:0] ExALUOp;
  logic [RA_W-1:0]    ExDst;
  logic               MemValid, MemMemRead, MemMemWrite, MemRegWrite, MemMemtoReg;
  logic [RA_W-1:0]    MemDst;
  logic               WbValid, WbRegWrite, WbMemtoReg;
  logic [RA_W-1:0]    WbDst;

  modport master (
    output InValid, Instruction, Function, Rs, Rt, Rd, Flush,
    input  Stall, IllegalOp,
    input  ExValid, ExRegDst, ExBranch, ExMemRead, ExMemtoReg, ExMemWrite,
    input  ExALUSrc, ExRegWrite, ExJump, ExJumpReg, ExLink, ExALUOp, ExDst,
    input  MemValid, MemMemRead, MemMemWrite, MemRegWrite, MemMemtoReg, MemDst,
    input  WbValid, WbRegWrite, WbMemtoReg, WbDst
  );

  modport slave (
    input  InValid, Instruction, Function, Rs, Rt, Rd, Flush,
    output Stall, IllegalOp,
    output ExValid, ExRegDst, ExBranch, ExMemRead, ExMemtoReg, ExMemWrite,
    output ExALUSrc, ExRegWrite, ExJump, ExJumpReg, ExLink, ExALUOp, ExDst,
    output MemValid, MemMemRead, MemMemWrite, MemRegWrite, MemMemtoReg, MemDst,
    output WbValid, WbRegWrite, WbMemtoReg, WbDst
  );
endinterface

// File: rtl/ctrl_pipe_unit.sv
// Pipelined control decoder: ID decode into ID/EX, carried through EX/MEM and MEM/WB, with load-use stall.
// Optional sticky illegal-decode trap when CTRL_ILLEGAL_TRAP_EN is defined; otherwise IllegalOp is 0.
module ctrl_pipe_unit #(
  parameter int ALUOP_W  = 4,
  parameter int RA_W     = 5,
  parameter int LINK_REG = 31
) (
  input  logic                 Clk,
  input  logic                 Rst,
  ctrl_pipe_unit_if.slave      bus
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_NOR   = 6'd39;
  localparam logic [5:0] FN_SLT   = 6'd42;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_NOR  = 4'd12;

  typedef struct packed {
    logic               valid;
    logic               regdst;
    logic               branch;
    logic               memread;
    logic               memtoreg;
    logic               memwrite;
    logic               alusrc;
    logic               regwrite;
    logic               jump;
    logic               jumpreg;
    logic               link;
    logic [ALUOP_W-1:0] aluop;
    logic [RA_W-1:0]    dst;
  } ex_t;

  typedef struct packed {
    logic            valid;
    logic            memread;
    logic            memwrite;
    logic            regwrite;
    logic            memtoreg;
    logic [RA_W-1:0] dst;
  } mem_t;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memtoreg;
    logic [RA_W-1:0] dst;
  } wb_t;

  ex_t  dec;
  logic legal;
  logic hazard;
  ex_t  ex_q;
  mem_t mem_q;
  wb_t  wb_q;

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (bus.Instruction)
      OP_RTYPE: begin
        dec.regdst   = 1'b1;
        dec.regwrite = 1'b1;
        case (bus.Function)
          FN_ADD: dec.aluop = ALUOP_W'(ALU_ADD);
          FN_AND: dec.aluop = ALUOP_W'(ALU_AND);
          FN_SLT: dec.aluop = ALUOP_W'(ALU_SLT);
          FN_NOR: dec.aluop = ALUOP_W'(ALU_NOR);
          FN_SLL: dec.aluop = ALUOP_W'(ALU_SLL);
          FN_JR: begin
            dec.jumpreg  = 1'b1;
            dec.regwrite = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = ALUOP_W'(ALU_ADD);
      end
      OP_ANDI: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = ALUOP_W'(ALU_AND);
      end
      OP_ORI: begin
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = ALUOP_W'(ALU_OR);
      end
      OP_LW: begin
        dec.alusrc   = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = ALUOP_W'(ALU_ADD);
      end
      OP_SW: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        dec.aluop    = ALUOP_W'(ALU_ADD);
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.aluop  = ALUOP_W'(ALU_SUB);
      end
      OP_J:   dec.jump = 1'b1;
      OP_JAL: begin
        dec.jump     = 1'b1;
        dec.link     = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = ALUOP_W'(ALU_ADD);
      end
      default: legal = 1'b0;
    endcase
    dec.valid = 1'b1;
    // Writeless instructions carry Dst=0 so the hazard compare ignores them.
    if (!dec.regwrite)   dec.dst = '0;
    else if (dec.link)   dec.dst = RA_W'(LINK_REG);
    else if (dec.regdst) dec.dst = bus.Rd;
    else                 dec.dst = bus.Rt;
  end

  assign hazard = ex_q.valid && ex_q.memread && (ex_q.dst != '0) &&
                  ((ex_q.dst == bus.Rs) || (ex_q.dst == bus.Rt)) && bus.InValid;

  assign bus.Stall = hazard && !bus.Flush;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      if (bus.Flush || hazard || !bus.InValid || !legal) ex_q <= '0;
      else                                               ex_q <= dec;
      mem_q <= '{valid: ex_q.valid, memread: ex_q.memread, memwrite: ex_q.memwrite,
                 regwrite: ex_q.regwrite, memtoreg: ex_q.memtoreg, dst: ex_q.dst};
      wb_q  <= '{valid: mem_q.valid, regwrite: mem_q.regwrite,
                 memtoreg: mem_q.memtoreg, dst: mem_q.dst};
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge Clk) begin
    if (Rst) illegal_q <= 1'b0;
    else if (bus.InValid && !legal && !bus.Flush && !hazard) illegal_q <= 1'b1;
  end

  assign bus.IllegalOp = illegal_q;
`else
  assign bus.IllegalOp = 1'b0;
`endif

  assign bus.ExValid    = ex_q.valid;
  assign bus.ExRegDst   = ex_q.regdst;
  assign bus.ExBranch   = ex_q.branch;
  assign bus.ExMemRead  = ex_q.memread;
  assign bus.ExMemtoReg = ex_q.memtoreg;
  assign bus.ExMemWrite = ex_q.memwrite;
  assign bus.ExALUSrc   = ex_q.alusrc;
  assign bus.ExRegWrite = ex_q.regwrite;
  assign bus.ExJump     = ex_q.jump;
  assign bus.ExJumpReg  = ex_q.jumpreg;
  assign bus.ExLink     = ex_q.link;
  assign bus.ExALUOp    = ex_q.aluop;
  assign bus.ExDst      = ex_q.dst;

  assign bus.MemValid    = mem_q.valid;
  assign bus.MemMemRead  = mem_q.memread;
  assign bus.MemMemWrite = mem_q.memwrite;
  assign bus.MemRegWrite = mem_q.regwrite;
  assign bus.MemMemtoReg = mem_q.memtoreg;
  assign bus.MemDst      = mem_q.dst;

  assign bus.WbValid    = wb_q.valid;
  assign bus.WbRegWrite = wb_q.regwrite;
  assign bus.WbMemtoReg = wb_q.memtoreg;
  assign bus.WbDst      = wb_q.dst;

endmodule
